pha_peak_detect: RTL and testbench

//  Pulse-height analyser front end. Sits between the 10-bit FADC input (WAVEX, sampled at 62.5 MHz)
//  and the SRAM waveform-memory writer.

---
 rtl/pha_peak_detect.sv | 170 +++++++++++++++++
 tb/tb_pha_peak_detect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pha_peak_detect.sv
// Pulse-height analyser front end: 8-sample moving average minus a lagged
// 8-sample baseline, LLD trigger, peak tracking and a one-deep PH output
// register towards the waveform-memory writer (valid/ready).
module pha_peak_detect #(
    parameter int DW        = 10,
    parameter int BASE_LAG  = 32,
    parameter int MAX_WIDTH = 255,
    parameter int DEAD      = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sample_en_i,
    input  logic [DW-1:0] wavex_i,
    input  logic          arm_i,
    input  logic [DW-1:0] lld_i,
    input  logic          ph_ready_i,
    output logic          ph_valid_o,
    output logic [DW-1:0] ph_o,
    output logic          trig_o,
    output logic [7:0]    ovf_cnt_o
);

    localparam int DEPTH = BASE_LAG + 8;
    localparam int SW    = DW + 3;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int WW    = $clog2(MAX_WIDTH + 1);
    localparam int CW    = $clog2(DEAD + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEEK, S_PEAK, S_HOLD} state_t;

    logic [DEPTH-1:0][DW-1:0] dly_q;
    logic [SW-1:0]            sum_a, sum_b, avg_a, avg_b;
    logic [DW-1:0]            h_d, h_q;
    logic                     en_q, arm_q;
    logic [FW-1:0]            fill_q, fill_d;
    state_t                   state_q, state_d;
    logic [DW-1:0]            pk_q, pk_d, pk_new;
    logic [WW-1:0]            wid_q, wid_d;
    logic [CW-1:0]            dcnt_q, dcnt_d;
    logic                     emit;
    logic                     ph_valid_q, ph_valid_d, trig_q, trig_d;
    logic [DW-1:0]            ph_q, ph_d;
    logic [7:0]               ovf_q, ovf_d;

    // Window sums: sumA includes the incoming sample, sumB is the window
    // that will sit at s(BASE_LAG)..s(BASE_LAG+7) after this shift.
    always_comb begin
        sum_a = SW'(wavex_i);
        for (int i = 0; i < 7; i++) sum_a = sum_a + SW'(dly_q[i]);
        sum_b = '0;
        for (int i = 0; i < 8; i++) sum_b = sum_b + SW'(dly_q[BASE_LAG-1+i]);
        avg_a = sum_a >> 3;
        avg_b = sum_b >> 3;
        h_d   = (avg_a > avg_b) ? DW'(avg_a - avg_b) : '0;
    end

    // Sample delay line, registered height and the one-CLK-delayed strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q <= '0;
            h_q   <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q <= sample_en_i;
            if (sample_en_i) begin
                dly_q <= {dly_q[DEPTH-2:0], wavex_i};
                h_q   <= h_d;
            end
        end
    end

    // Fill counter restarts on every arm rising edge, saturates at DEPTH.
    always_comb begin
        fill_d = fill_q;
        if (arm_i && !arm_q)
            fill_d = '0;
        else if (en_q && fill_q != FW'(DEPTH))
            fill_d = fill_q + FW'(1);
    end

    // Trigger FSM; steps on en_q, but disarm drops to IDLE immediately.
    always_comb begin
        state_d = state_q;
        pk_d    = pk_q;
        wid_d   = wid_q;
        dcnt_d  = dcnt_q;
        emit    = 1'b0;
        pk_new  = (h_q > pk_q) ? h_q : pk_q;
        if (!arm_i) begin
            state_d = S_IDLE;
        end else if (en_q) begin
            case (state_q)
                S_IDLE: state_d = S_SEEK;
                S_SEEK: begin
                    if (fill_q == FW'(DEPTH) && h_q > lld_i) begin
                        state_d = S_PEAK;
                        pk_d    = h_q;
                        wid_d   = WW'(1);
                    end
                end
                S_PEAK: begin
                    pk_d  = pk_new;
                    wid_d = wid_q + WW'(1);
                    if (h_q <= lld_i || wid_q == WW'(MAX_WIDTH)) begin
                        emit    = 1'b1;
                        dcnt_d  = CW'(DEAD);
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    dcnt_d = dcnt_q - CW'(1);
                    if (dcnt_q == CW'(1)) state_d = S_SEEK;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output register: load on emit when free or being drained, else count
    // a dropped event; a plain transfer empties the register.
    always_comb begin
        ph_d       = ph_q;
        ph_valid_d = ph_valid_q;
        ovf_d      = ovf_q;
        trig_d     = (state_d == S_PEAK);
        if (emit) begin
            if (!ph_valid_q || ph_ready_i) begin
                ph_d       = pk_new;
                ph_valid_d = 1'b1;
            end else if (ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 8'd1;
            end
        end else if (ph_valid_q && ph_ready_i) begin
            ph_valid_d = 1'b0;
        end
    end

    // State, event tracking and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arm_q      <= 1'b0;
            fill_q     <= '0;
            state_q    <= S_IDLE;
            pk_q       <= '0;
            wid_q      <= '0;
            dcnt_q     <= '0;
            ph_q       <= '0;
            ph_valid_q <= 1'b0;
            ovf_q      <= '0;
            trig_q     <= 1'b0;
        end else begin
            arm_q      <= arm_i;
            fill_q     <= fill_d;
            state_q    <= state_d;
            pk_q       <= pk_d;
            wid_q      <= wid_d;
            dcnt_q     <= dcnt_d;
            ph_q       <= ph_d;
            ph_valid_q <= ph_valid_d;
            ovf_q      <= ovf_d;
            trig_q     <= trig_d;
        end
    end

    assign ph_o       = ph_q;
    assign ph_valid_o = ph_valid_q;
    assign trig_o     = trig_q;
    assign ovf_cnt_o  = ovf_q;

endmodule

// File: tb/tb_pha_peak_detect.sv
// Directed bench for pha_peak_detect: expected PH words are queued when a
// pulse is issued and popped by a monitor on every PH transfer.
module tb_pha_peak_detect;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst, sample_en, arm, ph_ready;
    logic [DW-1:0] wavex, lld;
    logic          ph_valid, trig;
    logic [DW-1:0] ph;
    logic [7:0]    ovf;

    int n_chk = 0;
    int n_pass = 0;
    int trig_cnt;
    int r1, rf, r2;
    logic prev_trig;
    int exp_q[$];

    always #4 clk = ~clk;

    pha_peak_detect #(.DW(DW), .BASE_LAG(32), .MAX_WIDTH(255), .DEAD(16)) dut (
        .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en), .wavex_i(wavex),
        .arm_i(arm), .lld_i(lld), .ph_ready_i(ph_ready),
        .ph_valid_o(ph_valid), .ph_o(ph), .trig_o(trig), .ovf_cnt_o(ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One ADC sample: strobe for one CLK, then one idle CLK. Returns just
    // after the edge where the FSM has acted on this sample.
    task automatic smp(input int v);
        sample_en = 1'b1;
        wavex     = DW'(v);
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            smp(v);
            if (trig) trig_cnt++;
        end
    endtask

    // Monitor: every transfer must match the oldest expected PH.
    always @(negedge clk) begin
        if (!rst && ph_valid && ph_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL ph_unexpected: got PH=%0d, expected no event", ph);
            end else begin
                chk("ph_value", int'(ph), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; sample_en = 1'b0; wavex = '0; arm = 1'b0;
        lld = DW'(50); ph_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_ph_valid", ph_valid, 0);
        chk("rst_ph", ph, 0);
        chk("rst_trig", trig, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0; arm = 1'b1;
        @(posedge clk); #1;

        // 1: single pulse 400 on baseline 100 -> PH=300
        trig_cnt = 0;
        run(100, 64);
        chk("t1_no_trig_baseline", trig_cnt, 0);
        exp_q.push_back(300);
        run(400, 8);
        run(100, 6);
        chk("t1_valid_before_emit", ph_valid, 0);
        smp(100);
        chk("t1_emit_latency", ph_valid, 1);
        chk("t1_trig_low_after", trig, 0);
        chk("t1_trig_samples", trig_cnt, 13);
        run(100, 50);

        // 2: re-arm, pulse during priming ignored, later pulse detected
        arm = 1'b0;
        run(100, 5);
        arm = 1'b1;
        trig_cnt = 0;
        run(100, 9);
        run(400, 8);
        run(100, 42);
        chk("t2_priming_no_trig", trig_cnt, 0);
        exp_q.push_back(300);
        run(400, 8);
        run(100, 40);
        chk("t2_trig_after_fill", trig_cnt, 13);

        // 3: writer stalled, second event dropped
        ph_ready = 1'b0;
        run(100, 5);
        exp_q.push_back(300);
        run(400, 8);
        run(100, 92);
        chk("t3_held_valid", ph_valid, 1);
        chk("t3_ovf_before", ovf, 0);
        run(400, 8);
        run(100, 40);
        chk("t3_ovf", ovf, 1);
        chk("t3_ph_stable", ph, 300);
        chk("t3_valid_kept", ph_valid, 1);
        ph_ready = 1'b1;
        @(posedge clk); #1;
        ph_ready = 1'b0;
        chk("t3_valid_cleared", ph_valid, 0);
        ph_ready = 1'b1;

        // 4: ramp, h=32 steady, forced emit at max width, dead time
        lld = DW'(20);
        exp_q.push_back(32);
        exp_q.push_back(32);
        r1 = -1; rf = -1; r2 = -1; prev_trig = 1'b0;
        for (int r = 0; r < 300; r++) begin
            smp(100 + r);
            if (trig && !prev_trig) begin
                if (r1 < 0) r1 = r; else if (r2 < 0) r2 = r;
            end
            if (!trig && prev_trig && rf < 0) rf = r;
            prev_trig = trig;
        end
        chk("t4_first_trig_sample", r1, 25);
        chk("t4_forced_emit_sample", rf, 280);
        chk("t4_retrig_sample", r2, 297);
        smp(100);
        chk("t4_trig_drop", trig, 0);
        run(100, 45);
        chk("t4_ovf", ovf, 1);

        // 5: dip below baseline clamps to 0, no trigger
        rst = 1'b1; lld = DW'(50);
        @(posedge clk); #1;
        rst = 1'b0;
        trig_cnt = 0;
        run(300, 50);
        run(100, 8);
        run(300, 20);
        chk("t5_no_trig", trig_cnt, 0);
        chk("t5_ovf", ovf, 0);
        arm = 1'b0;
        run(300, 2);

        // 6: reset during PEAK, then disarm during PEAK
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; arm = 1'b1; ph_ready = 1'b0;
        run(100, 50);
        run(400, 8);
        run(100, 45);
        run(400, 3);
        chk("t6_in_peak", trig, 1);
        chk("t6_pending", ph_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_trig", trig, 0);
        chk("t6_rst_valid", ph_valid, 0);
        chk("t6_rst_ph", ph, 0);
        @(posedge clk); #1;
        rst = 1'b0; ph_ready = 1'b1;
        trig_cnt = 0;
        run(400, 5);
        run(100, 60);
        chk("t6_no_partial_event", trig_cnt, 0);
        run(400, 4);
        chk("t6_peak_again", trig, 1);
        arm = 1'b0;
        @(posedge clk); #1;
        chk("t6_disarm_trig", trig, 0);
        trig_cnt = 0;
        run(400, 4);
        run(100, 20);
        chk("t6_disarm_idle", trig_cnt, 0);
        chk("t6_no_emit", ph_valid, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
